// File: rtl/cmd_stream_bram.sv
// Command-stream RAM with a built-in fetch engine.
// The host loads a packed list of header words, each followed by N payload
// words. The engine walks the list and presents each command as one parallel
// packet (header + payload lanes) on a valid/ready port.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; latches list bounds and clears err on start
// HDR   | 3 phases: issue header read, capture header, decode/check it
// PAY   | one cycle per payload word, filling lanes 0..N-1 in order
// EMIT  | cmd_valid high; packet held stable until the consumer takes it
//
// The header is captured into its own register one phase before decode.
// The PAY read pipeline is one word deep. With these two stages, valid
// rises N+3 edges after start or after a handshake, whatever N is.
module cmd_stream_bram #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int MAX_PAYLOAD = 4
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 wr_en,
    input  logic [ADDR_W-1:0]                    wr_addr,
    input  logic [DATA_W-1:0]                    wr_data,
    input  logic                                 start,
    input  logic [ADDR_W-1:0]                    start_addr,
    input  logic [ADDR_W-1:0]                    end_addr,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 err,
    output logic                                 cmd_valid,
    input  logic                                 cmd_ready,
    output logic [DATA_W-1:0]                    cmd_header,
    output logic [MAX_PAYLOAD*DATA_W-1:0]        cmd_payload,
    output logic [$clog2(MAX_PAYLOAD+1)-1:0]     cmd_count
);

    localparam int DEPTH = 2**ADDR_W;
    localparam int CNT_W = $clog2(MAX_PAYLOAD+1);
    localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_TWO = ADDR_W'(2);
    localparam logic [CNT_W-1:0]  C_ONE = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, HDR, PAY, EMIT} state_t;

    state_t             state, state_nxt;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DATA_W-1:0]  rd_data;
    logic [ADDR_W-1:0]  rd_addr;
    logic [ADDR_W-1:0]  ptr;
    logic [ADDR_W-1:0]  end_q;
    logic [ADDR_W-1:0]  ptr_next;
    logic [DATA_W-1:0]  hdr_q;
    logic [1:0]         hdr_phase;
    logic [CNT_W-1:0]   pay_idx;
    logic [7:0]         hdr_n;
    logic               hdr_flag;
    logic               hdr_bad;
    logic               pay_last;
    logic               done_nxt;

    assign hdr_n    = hdr_q[15:8];
    assign hdr_flag = hdr_q[31];
    assign hdr_bad  = (hdr_n > 8'(MAX_PAYLOAD)) ||
                      (hdr_flag && (hdr_n == 8'd0)) ||
                      (!hdr_flag && (hdr_n != 8'd0));
    assign pay_last = (pay_idx == (cmd_count - C_ONE));
    // End is compared only here, at a header boundary, so a payload that
    // straddles end is still fetched in full.
    assign ptr_next = ptr + A_ONE + ADDR_W'(cmd_count);

    assign busy      = (state != IDLE);
    assign cmd_valid = (state == EMIT);

    // RAM: one write port and one registered read port. Old data is returned
    // on a same-address collision. Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, read address and done request
    always_comb begin
        state_nxt = state;
        rd_addr   = ptr;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    if (start_addr == end_addr) begin
                        done_nxt = 1'b1;
                    end else begin
                        state_nxt = HDR;
                    end
                end
            end
            HDR: begin
                // Phase 0 reads the header. Later phases prefetch payload word 0.
                rd_addr = (hdr_phase == 2'd0) ? ptr : ptr + A_ONE;
                if (hdr_phase == 2'd2) begin
                    if (hdr_bad) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else if (hdr_n == 8'd0) begin
                        state_nxt = EMIT;
                    end else begin
                        state_nxt = PAY;
                    end
                end
            end
            PAY: begin
                rd_addr = ptr + A_TWO + ADDR_W'(pay_idx);
                if (pay_last) begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                if (cmd_ready) begin
                    if (ptr_next == end_q) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = HDR;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: pointers, header decode, lane fill and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= '0;
            end_q       <= '0;
            hdr_q       <= '0;
            hdr_phase   <= '0;
            pay_idx     <= '0;
            cmd_header  <= '0;
            cmd_payload <= '0;
            cmd_count   <= '0;
            err         <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= done_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        ptr   <= start_addr;
                        end_q <= end_addr;
                        err   <= 1'b0;
                    end
                end
                HDR: begin
                    hdr_phase <= (hdr_phase == 2'd2) ? 2'd0 : hdr_phase + 2'd1;
                    if (hdr_phase == 2'd1) begin
                        hdr_q <= rd_data;
                    end
                    if (hdr_phase == 2'd2) begin
                        if (hdr_bad) begin
                            err <= 1'b1;
                        end else begin
                            cmd_header  <= hdr_q;
                            cmd_count   <= CNT_W'(hdr_n);
                            cmd_payload <= '0;
                            pay_idx     <= '0;
                        end
                    end
                end
                PAY: begin
                    for (int i = 0; i < MAX_PAYLOAD; i++) begin
                        if (pay_idx == CNT_W'(i)) begin
                            cmd_payload[i*DATA_W +: DATA_W] <= rd_data;
                        end
                    end
                    pay_idx <= pay_idx + C_ONE;
                end
                EMIT: begin
                    if (cmd_ready) begin
                        ptr <= ptr_next;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_stream_bram.sv
// Testbench for cmd_stream_bram. Expected packets go into a scoreboard
// queue when a fetch is started. A negedge monitor compares them with every
// valid cycle and pops an entry on each handshake.
module tb_cmd_stream_bram;

    logic         clk;
    logic         rst_n;
    logic         wr_en;
    logic [7:0]   wr_addr;
    logic [31:0]  wr_data;
    logic         start;
    logic [7:0]   start_addr;
    logic [7:0]   end_addr;
    logic         busy;
    logic         done;
    logic         err;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [31:0]  cmd_header;
    logic [127:0] cmd_payload;
    logic [2:0]   cmd_count;

    typedef struct {
        logic [31:0]  hdr;
        logic [2:0]   cnt;
        logic [127:0] pl;
    } pkt_t;

    typedef struct {
        logic [31:0]      hdr;
        logic [3:0][31:0] words;
        logic             exp_err;
        int               exp_cnt;
    } vec_t;

    pkt_t sb[$];
    vec_t vecs[7];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pkts     = 0;

    cmd_stream_bram #(.DATA_W(32), .ADDR_W(8), .MAX_PAYLOAD(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .start      (start),
        .start_addr (start_addr),
        .end_addr   (end_addr),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_header (cmd_header),
        .cmd_payload(cmd_payload),
        .cmd_count  (cmd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic pkt_t make_pkt(input logic [31:0] hdr, input int cnt,
                                      input logic [3:0][31:0] words);
        pkt_t p;
        p.hdr = hdr;
        p.cnt = 3'(cnt);
        p.pl  = '0;
        for (int i = 0; i < cnt; i++) p.pl[i*32 +: 32] = words[i];
        return p;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [7:0] a, input logic [31:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_start(input logic [7:0] s, input logic [7:0] e);
        start = 1'b1; start_addr = s; end_addr = e;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int edges);
        edges = 0;
        while (!cmd_valid && edges < max) begin
            tick();
            edges++;
        end
        if (!cmd_valid) begin
            n_checks++; n_fail++;
            $display("FAIL valid_timeout: cmd_valid still 0 after %0d cycles, required 1", edges);
        end
    endtask

    task automatic wait_done(input int max, output int edges);
        edges = 0;
        while (!done && edges < max) begin
            tick();
            edges++;
        end
        if (!done) begin
            n_checks++; n_fail++;
            $display("FAIL done_timeout: done still 0 after %0d cycles, required 1", edges);
        end
    endtask

    // Scoreboard monitor: every valid cycle must match the queue head
    always @(negedge clk) begin
        if (rst_n && cmd_valid) begin
            if (sb.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL unexpected_packet: got hdr %h with empty scoreboard, required no packet", cmd_header);
            end else begin
                check("pkt_header", cmd_header, sb[0].hdr);
                check("pkt_count", cmd_count, sb[0].cnt);
                check("pkt_payload", cmd_payload, sb[0].pl);
                if (cmd_ready) begin
                    void'(sb.pop_front());
                    pkts++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e;
        int p0;
        logic [7:0] base;
        logic [3:0][31:0] w;

        rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; start_addr = '0; end_addr = '0; cmd_ready = 1'b1;

        vecs[0] = '{32'h80000304, {32'h5555AAAA, 32'h00000000, 32'h3F000000, 32'h3F800000}, 1'b0, 3};
        vecs[1] = '{32'h00000010, {32'hDEAD0004, 32'hDEAD0003, 32'hDEAD0002, 32'hDEAD0001}, 1'b0, 0};
        vecs[2] = '{32'h80000513, {32'hBAD00004, 32'hBAD00003, 32'hBAD00002, 32'hBAD00001}, 1'b1, 0};
        vecs[3] = '{32'h80000401, {32'hA4A4A4A4, 32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1}, 1'b0, 4};
        vecs[4] = '{32'h80000020, {32'hC0000004, 32'hC0000003, 32'hC0000002, 32'hC0000001}, 1'b1, 0};
        vecs[5] = '{32'h80000102, {32'hB0000004, 32'hB0000003, 32'hB0000002, 32'hB0000001}, 1'b0, 1};
        vecs[6] = '{32'h00000205, {32'hE0000004, 32'hE0000003, 32'hE0000002, 32'hE0000001}, 1'b1, 0};

        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_valid", cmd_valid, 0);
        check("rst_header", cmd_header, 0);
        check("rst_payload", cmd_payload, 0);
        check("rst_count", cmd_count, 0);
        rst_n = 1'b1;
        tick();

        // Table-driven single-command runs
        for (int v = 0; v < 7; v++) begin
            base = 8'(8'h20 + v * 16);
            write_word(base, vecs[v].hdr);
            for (int j = 0; j < 4; j++) write_word(base + 8'(1 + j), vecs[v].words[j]);
            if (!vecs[v].exp_err) sb.push_back(make_pkt(vecs[v].hdr, vecs[v].exp_cnt, vecs[v].words));
            pulse_start(base, base + 8'(1 + vecs[v].exp_cnt));
            check("start_clears_err", err, 0);
            check("busy_after_start", busy, 1);
            if (!vecs[v].exp_err) begin
                wait_valid(20, e);
                check("first_valid_latency", e, vecs[v].exp_cnt + 3);
                tick();
                check("done_after_handshake", done, 1);
                check("idle_after_last", busy, 0);
                tick();
                check("done_one_cycle", done, 0);
            end else begin
                wait_done(20, e);
                check("err_done_latency", e, 3);
                check("err_set", err, 1);
                check("err_no_valid", cmd_valid, 0);
                tick();
                check("err_done_one_cycle", done, 0);
                check("err_sticky", err, 1);
                check("err_idle", busy, 0);
            end
        end

        // T2: four packets, consumer stalled for 5 cycles, back-to-back timing
        p0 = pkts;
        for (int k = 0; k < 4; k++) begin
            w[0] = 32'h10000000 + 32'(k * 16 + 1);
            w[1] = 32'h10000000 + 32'(k * 16 + 2);
            w[2] = 32'h10000000 + 32'(k * 16 + 3);
            w[3] = 32'h0;
            write_word(8'(k * 4), (k == 0) ? 32'h80000304 : 32'h80000303);
            for (int j = 0; j < 3; j++) write_word(8'(k * 4 + 1 + j), w[j]);
            sb.push_back(make_pkt((k == 0) ? 32'h80000304 : 32'h80000303, 3, w));
        end
        cmd_ready = 1'b0;
        pulse_start(8'h00, 8'h10);
        check("t2_err_cleared", err, 0);
        wait_valid(20, e);
        check("t2_first_latency", e, 6);
        repeat (5) tick();
        check("t2_no_pop_while_stalled", pkts - p0, 0);
        check("t2_still_valid", cmd_valid, 1);
        cmd_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (k < 3) begin
                wait_valid(20, e);
                check("t2_b2b_latency", e, 6);
            end else begin
                check("t2_done", done, 1);
            end
        end
        check("t2_packets", pkts - p0, 4);
        check("t2_sb_empty", sb.size(), 0);

        // T3: N=0 header at 0xFE, payload wrapping 0xFF -> 0x00..0x02
        p0 = pkts;
        write_word(8'hFE, 32'h00000010);
        write_word(8'hFF, 32'h80000304);
        write_word(8'h00, 32'h3F800000);
        write_word(8'h01, 32'h3F000000);
        write_word(8'h02, 32'h40000000);
        w = '0;
        sb.push_back(make_pkt(32'h00000010, 0, w));
        w[0] = 32'h3F800000; w[1] = 32'h3F000000; w[2] = 32'h40000000;
        sb.push_back(make_pkt(32'h80000304, 3, w));
        pulse_start(8'hFE, 8'h03);
        wait_valid(20, e);
        check("t3_n0_latency", e, 3);
        tick();
        wait_valid(20, e);
        check("t3_wrap_latency", e, 6);
        tick();
        check("t3_done", done, 1);
        check("t3_packets", pkts - p0, 2);

        // T5: reset while a packet is held in EMIT, then re-run T1
        w[0] = 32'h3F800000; w[1] = 32'h3F000000; w[2] = 32'h0; w[3] = 32'h0;
        write_word(8'h00, 32'h80000304);
        for (int j = 0; j < 3; j++) write_word(8'(1 + j), w[j]);
        sb.push_back(make_pkt(32'h80000304, 3, w));
        cmd_ready = 1'b0;
        pulse_start(8'h00, 8'h04);
        wait_valid(20, e);
        #2 rst_n = 1'b0;
        #1;
        check("t5_valid_async", cmd_valid, 0);
        check("t5_busy_async", busy, 0);
        check("t5_header_async", cmd_header, 0);
        check("t5_payload_async", cmd_payload, 0);
        check("t5_count_async", cmd_count, 0);
        sb.delete();
        tick();
        rst_n = 1'b1;
        tick();
        check("t5_no_done", done, 0);
        cmd_ready = 1'b1;
        p0 = pkts;
        sb.push_back(make_pkt(32'h80000304, 3, w));
        pulse_start(8'h00, 8'h04);
        wait_valid(20, e);
        check("t5_rerun_latency", e, 6);
        tick();
        check("t5_rerun_done", done, 1);
        check("t5_rerun_packets", pkts - p0, 1);

        // T6: ignored start while busy, same-cycle write/read, immediate done
        write_word(8'h40, 32'h80000102);
        write_word(8'h41, 32'h11111111);
        w = '0; w[0] = 32'h11111111;
        sb.push_back(make_pkt(32'h80000102, 1, w));
        pulse_start(8'h40, 8'h42);
        wr_en = 1'b1; wr_addr = 8'h40; wr_data = 32'h00000077;
        start = 1'b1; start_addr = 8'h50; end_addr = 8'h50;
        tick();
        wr_en = 1'b0; start = 1'b0;
        check("t6_busy_start_ignored", done, 0);
        check("t6_still_busy", busy, 1);
        wait_valid(20, e);
        check("t6_latency", e, 3);
        tick();
        check("t6_done", done, 1);
        tick();
        pulse_start(8'h30, 8'h30);
        check("t6_empty_done", done, 1);
        check("t6_empty_idle", busy, 0);
        check("t6_empty_no_valid", cmd_valid, 0);
        tick();
        check("t6_empty_done_pulse", done, 0);
        w = '0;
        sb.push_back(make_pkt(32'h00000077, 0, w));
        pulse_start(8'h40, 8'h41);
        wait_valid(20, e);
        check("t6_new_word_latency", e, 3);
        tick();
        check("t6_new_word_done", done, 1);

        tick();
        check("final_sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
